dot_mmio_sink: RTL and testbench

//  Receiving end of the processor's dot-location MMIO stores (X at 100-549, Y at 550-999).

---
 rtl/dot_mmio_sink.sv | 196 +++++++++++++++++++
 tb/tb_dot_mmio_sink.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_mmio_sink.sv
// Dot-location MMIO sink: buffers processor X/Y stores in a FIFO and
// drains them into a per-dot position table read by the pixel renderer.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   dotWren             store strobe (one store per cycle)
//   is_Yloc             1 = store targets Y, 0 = store targets X
//   dotID, dotLoc       dot index and raw coordinate from the processor
//   rd_req, rd_id       renderer read request and dot index
//   rd_valid, rd_x/rd_y read response, one cycle after rd_req
//   pending             store FIFO not empty
//   clearing            table clear walk in progress
//   fifo_full           store FIFO holds FIFO_DEPTH entries
//   drop_cnt            dropped stores, saturating at 255
module dot_mmio_sink #(
  parameter int unsigned NUM_DOTS   = 450,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned X_MAX      = 639,
  parameter int unsigned Y_MAX      = 479
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dotWren,
  input  logic               is_Yloc,
  input  logic [31:0]        dotID,
  input  logic [31:0]        dotLoc,
  input  logic               rd_req,
  input  logic [8:0]         rd_id,
  output logic               rd_valid,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  output logic               pending,
  output logic               clearing,
  output logic               fifo_full,
  output logic [7:0]         drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = 9;

  localparam logic [COORD_W-1:0] XM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MAX);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_DOTS - 1);
  localparam logic [IW-1:0] ID_LIM  = IW'(NUM_DOTS);

  typedef struct packed {
    logic               ysel;
    logic [IW-1:0]      id;
    logic [COORD_W-1:0] coord;
  } entry_t;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t        state;
  logic [IW-1:0] clr_idx;

  entry_t        fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  entry_t        head;

  logic [COORD_W-1:0] tab_x [NUM_DOTS];
  logic [COORD_W-1:0] tab_y [NUM_DOTS];

  logic               id_ok;
  logic               over;
  logic [COORD_W-1:0] clamped;
  logic               do_pop;
  logic               do_push;
  logic               do_drop;
  logic               rd_ok;

  // ---------------- store path ----------------
  always_comb begin
    id_ok = dotID < 32'(NUM_DOTS);
    over  = is_Yloc ? (dotLoc > 32'(Y_MAX))
                    : (dotLoc > 32'(X_MAX));
    if (over)
      clamped = is_Yloc ? YM : XM;
    else
      clamped = dotLoc[COORD_W-1:0];
  end

  // Pointers carry one extra wrap bit so full and
  // empty are distinguishable without a counter.
  assign pending   = (wr_ptr != rd_ptr);
  assign fifo_full = (wr_ptr[PW] != rd_ptr[PW]) &&
                     (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head      = fifo_mem[rd_ptr[PW-1:0]];

  // Reads own the table port, so they stall draining.
  assign do_pop  = (state == ST_RUN) && pending && !rd_req;
  // A full FIFO still accepts when a pop frees a slot.
  assign do_push = dotWren && id_ok && (!fifo_full || do_pop);
  assign do_drop = dotWren && !do_push;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= '{
        ysel:  is_Yloc,
        id:    dotID[IW-1:0],
        coord: clamped
      };
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      drop_cnt <= '0;
    else if (do_drop && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end

  // ---------------- clear walk ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_CLEAR;
      clr_idx  <= '0;
      clearing <= 1'b1;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          if (clr_idx == LAST_ID) begin
            state    <= ST_RUN;
            clr_idx  <= '0;
            clearing <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state    <= ST_CLEAR;
          clr_idx  <= '0;
          clearing <= 1'b1;
        end
      endcase
    end
  end

  // ---------------- position table ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        tab_x[clr_idx] <= '0;
        tab_y[clr_idx] <= '0;
      end else if (do_pop) begin
        if (head.ysel)
          tab_y[head.id] <= head.coord;
        else
          tab_x[head.id] <= head.coord;
      end
    end
  end

  // ---------------- read port ----------------
  assign rd_ok = rd_id < ID_LIM;

  // Entries not yet reached by the clear walk may
  // hold stale data, so reads in CLEAR return zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_x     <= '0;
      rd_y     <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        if (state == ST_CLEAR || !rd_ok) begin
          rd_x <= '0;
          rd_y <= '0;
        end else begin
          rd_x <= tab_x[rd_id];
          rd_y <= tab_y[rd_id];
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_mmio_sink.sv
// Self-checking bench for dot_mmio_sink: directed stores/reads compared
// every cycle against a queue-and-array model plus literal expectations.
module tb_dot_mmio_sink;

  localparam int ND = 450;

  logic        clk = 1'b0;
  logic        reset;
  logic        dotWren;
  logic        is_Yloc;
  logic [31:0] dotID;
  logic [31:0] dotLoc;
  logic        rd_req;
  logic [8:0]  rd_id;
  logic        rd_valid;
  logic [9:0]  rd_x;
  logic [9:0]  rd_y;
  logic        pending;
  logic        clearing;
  logic        fifo_full;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  dot_mmio_sink dut (
    .clock     (clk),
    .reset     (reset),
    .dotWren   (dotWren),
    .is_Yloc   (is_Yloc),
    .dotID     (dotID),
    .dotLoc    (dotLoc),
    .rd_req    (rd_req),
    .rd_id     (rd_id),
    .rd_valid  (rd_valid),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .pending   (pending),
    .clearing  (clearing),
    .fifo_full (fifo_full),
    .drop_cnt  (drop_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    bit y;
    int id;
    int v;
  } ent_t;

  ent_t q[$];
  int   mx [ND];
  int   my [ND];
  int   m_drop;
  int   m_cyc;
  bit   m_rv;
  int   m_rx;
  int   m_ry;
  bit   armed = 0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      for (int i = 0; i < ND; i++) begin
        mx[i] = 0;
        my[i] = 0;
      end
      m_drop = 0;
      m_cyc  = 0;
      m_rv   = 0;
      m_rx   = 0;
      m_ry   = 0;
      armed  = 1;
    end else begin
      bit   in_clear;
      bit   pop;
      bit   was_full;
      int   lim;
      ent_t h;
      ent_t e;
      in_clear = m_cyc < ND;
      was_full = q.size() == 8;
      pop      = !in_clear && q.size() > 0 && !rd_req;
      m_rv     = rd_req;
      if (rd_req) begin
        if (in_clear || rd_id >= ND) begin
          m_rx = 0;
          m_ry = 0;
        end else begin
          m_rx = mx[rd_id];
          m_ry = my[rd_id];
        end
      end
      if (pop) begin
        h = q.pop_front();
        if (h.y) my[h.id] = h.v;
        else     mx[h.id] = h.v;
      end
      if (dotWren) begin
        if (dotID >= ND || (was_full && !pop)) begin
          if (m_drop < 255) m_drop++;
        end else begin
          lim  = is_Yloc ? 479 : 639;
          e.y  = is_Yloc;
          e.id = int'(dotID);
          e.v  = (dotLoc > lim) ? lim : int'(dotLoc[9:0]);
          q.push_back(e);
        end
      end
      if (m_cyc < ND) m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("pending",   32'(pending),   32'(q.size() != 0));
      chk("fifo_full", 32'(fifo_full), 32'(q.size() == 8));
      chk("clearing",  32'(clearing),  32'(m_cyc < ND));
      chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
      chk("rd_valid",  32'(rd_valid),  32'(m_rv));
      if (m_rv) begin
        chk("rd_x", 32'(rd_x), 32'(m_rx));
        chk("rd_y", 32'(rd_y), 32'(m_ry));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input bit y, input int id, input int v);
    dotWren = 1'b1;
    is_Yloc = y;
    dotID   = id;
    dotLoc  = v;
    tick();
    dotWren = 1'b0;
  endtask

  task automatic rd(input int id, input int ex, input int ey,
                    input string nm);
    rd_req = 1'b1;
    rd_id  = 9'(id);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(rd_valid), 32'd1);
    chk({nm, "_x"},     32'(rd_x),     32'(ex));
    chk({nm, "_y"},     32'(rd_y),     32'(ey));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    dotWren = 1'b0;
    is_Yloc = 1'b0;
    dotID   = '0;
    dotLoc  = '0;
    rd_req  = 1'b0;
    rd_id   = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid",    32'(rd_valid), 32'd0);
    chk("rst_x",        32'(rd_x),     32'd0);
    chk("rst_y",        32'(rd_y),     32'd0);
    chk("rst_drop",     32'(drop_cnt), 32'd0);
    chk("rst_pending",  32'(pending),  32'd0);
    chk("rst_clearing", 32'(clearing), 32'd1);
    reset = 1'b0;

    // 1: clear lasts exactly 450 cycles
    repeat (449) tick();
    @(negedge clk);
    chk("clr_449", 32'(clearing), 32'd1);
    tick();
    @(negedge clk);
    chk("clr_450", 32'(clearing), 32'd0);
    rd(5, 0, 0, "t1_rd5");

    // 2: X then Y to id 3
    store(0, 3, 200);
    store(1, 3, 150);
    tick();
    @(negedge clk);
    chk("t2_pending", 32'(pending), 32'd0);
    rd(3, 200, 150, "t2_rd3");

    // 3: clamping and last-write-wins
    store(0, 7, 900);
    store(1, 7, 600);
    store(0, 8, 639);
    store(1, 8, 480);
    store(0, 9, 10);
    store(0, 9, 20);
    repeat (4) tick();
    rd(7, 639, 479, "t3_rd7");
    rd(8, 639, 479, "t3_rd8");
    rd(9, 20, 0, "t3_rd9");
    rd(460, 0, 0, "t3_rd460");

    // 4: stores during CLEAR, overflow drops
    do_reset();
    rd(3, 0, 0, "t4_clr_rd3");
    for (int i = 0; i < 10; i++) store(0, i, 100 + i);
    @(negedge clk);
    chk("t4_full", 32'(fifo_full), 32'd1);
    chk("t4_drop", 32'(drop_cnt),  32'd2);
    repeat (450) tick();
    @(negedge clk);
    chk("t4_drained", 32'(pending), 32'd0);
    for (int i = 0; i < 8; i++) rd(i, 100 + i, 0, "t4_rd");
    rd(8, 0, 0, "t4_rd8");
    rd(9, 0, 0, "t4_rd9");

    // 7: full with simultaneous pop accepts, without pop drops
    rd_req = 1'b1;
    rd_id  = '0;
    for (int i = 0; i < 8; i++) store(0, 30 + i, 300 + i);
    @(negedge clk);
    chk("t7_full", 32'(fifo_full), 32'd1);
    rd_req = 1'b0;
    store(0, 38, 338);
    @(negedge clk);
    chk("t7_accept", 32'(drop_cnt), 32'd2);
    rd_req = 1'b1;
    store(0, 39, 339);
    rd_req = 1'b0;
    @(negedge clk);
    chk("t7_drop", 32'(drop_cnt), 32'd3);
    repeat (10) tick();
    rd(30, 300, 0, "t7_rd30");
    rd(38, 338, 0, "t7_rd38");
    rd(39, 0, 0, "t7_rd39");

    // 5: reads held high stall draining
    rd_req = 1'b1;
    rd_id  = 9'd4;
    store(0, 20, 55);
    repeat (19) begin
      @(negedge clk);
      chk("t5_hold", 32'(pending), 32'd1);
      tick();
    end
    rd_req = 1'b0;
    tick();
    @(negedge clk);
    chk("t5_pop", 32'(pending), 32'd0);
    rd(20, 55, 0, "t5_rd20");

    // 6: bad id, saturation, reset mid-CLEAR
    store(0, 450, 5);
    @(negedge clk);
    chk("t6_badid", 32'(drop_cnt), 32'd4);
    rd(450, 0, 0, "t6_rd450");
    dotWren = 1'b1;
    dotID   = 32'd500;
    repeat (260) tick();
    dotWren = 1'b0;
    @(negedge clk);
    chk("t6_sat", 32'(drop_cnt), 32'd255);
    do_reset();
    repeat (200) tick();
    store(1, 1, 77);
    @(negedge clk);
    chk("t6_pend", 32'(pending), 32'd1);
    do_reset();
    @(negedge clk);
    chk("t6_rst_pend", 32'(pending),  32'd0);
    chk("t6_rst_clr",  32'(clearing), 32'd1);
    chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
    repeat (449) tick();
    @(negedge clk);
    chk("t6_clr_449", 32'(clearing), 32'd1);
    tick();
    @(negedge clk);
    chk("t6_clr_450", 32'(clearing), 32'd0);
    rd(1, 0, 0, "t6_rd1");
    rd(20, 0, 0, "t6_rd20");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
